// File: rtl/multi_ctrl_fsm.sv
// multi_ctrl_fsm: main control FSM of the multi-cycle MIPS datapath.
// Inputs : clk, rst_n (async active-low), opcode (IR[31:26]), mem_ready (memory handshake).
// Outputs: datapath enables/muxes (PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite,
//          IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero), ALUop,
//          state (debug), illegal_op (sticky), instr_done (retire pulse), retired (count).
module multi_ctrl_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             ExtZero,
  output logic [1:0]       ALUop,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [3:0] {
    S_RST, S_IF, S_ID, S_MA, S_MRD, S_WBL, S_MWR, S_EXR, S_WBR, S_BR, S_JMP, S_EXI, S_WBI
  } state_t;
  state_t           r_state, w_next;
  logic             r_ext, r_illegal, r_done;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire, w_illegal, w_ext;
  // andi/ori/xori (0011xx) zero-extend; addi/slti sign-extend
  assign w_ext      = opcode[5:2] == 4'b0011;
  assign state      = r_state;
  assign illegal_op = r_illegal;
  assign instr_done = r_done;
  assign retired    = r_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RST;
      r_ext     <= 1'b0;
      r_illegal <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_next;
      r_ext     <= r_state == S_EXI ? w_ext : r_ext;
      r_illegal <= r_illegal | w_illegal;
      r_done    <= w_retire;
      r_cnt     <= r_cnt + CNT_W'(w_retire);
    end
  end
  always_comb begin
    w_next      = S_IF;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ExtZero     = 1'b0;
    ALUop       = 2'b00;
    case (r_state)
      S_IF: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        w_next  = mem_ready ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB = 2'b11;
        case (opcode)
          6'b000000:                   w_next = S_EXR;
          6'b100011, 6'b101011:        w_next = S_MA;
          6'b000100:                   w_next = S_BR;
          6'b000010:                   w_next = S_JMP;
          6'b001000, 6'b001010,
          6'b001100, 6'b001101,
          6'b001110:                   w_next = S_EXI;
          default:                     w_illegal = 1'b1;
        endcase
      end
      S_MA: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = opcode == 6'b100011 ? S_MRD : S_MWR;
      end
      S_MRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = mem_ready ? S_WBL : S_MRD;
      end
      S_WBL: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_retire = 1'b1;
      end
      S_MWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_retire = mem_ready;
        w_next   = mem_ready ? S_IF : S_MWR;
      end
      S_EXR: begin
        ALUSrcA = 1'b1;
        ALUop   = 2'b10;
        w_next  = S_WBR;
      end
      S_WBR: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_retire = 1'b1;
      end
      S_BR: begin
        ALUSrcA     = 1'b1;
        ALUop       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_retire    = 1'b1;
      end
      S_JMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_retire = 1'b1;
      end
      S_EXI: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUop   = 2'b11;
        ExtZero = w_ext;
        w_next  = S_WBI;
      end
      S_WBI: begin
        RegWrite = 1'b1;
        ExtZero  = r_ext;
        w_retire = 1'b1;
      end
      default: w_next = S_IF;
    endcase
  end
endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// tb_multi_ctrl_fsm: directed self-checking bench for multi_ctrl_fsm.
module tb_multi_ctrl_fsm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = 6'b0;
  logic        mem_ready = 1'b1;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, ExtZero, illegal_op, instr_done;
  logic [1:0]  PCSource, ALUSrcB, ALUop;
  logic [3:0]  state;
  logic [31:0] retired;
  logic [16:0] ctl;
  int          checks = 0;
  int          errors = 0;
  // ctl order: PCW PCWC PCS[1:0] IorD MR MW IRW M2R RDst RW ASA ASB[1:0] EZ ALUop[1:0]
  localparam logic [16:0] C_ZERO = 17'b0;
  localparam logic [16:0] C_IF1  = 17'b1_0_00_0_1_0_1_0_0_0_0_01_0_00;
  localparam logic [16:0] C_IF0  = 17'b0_0_00_0_1_0_0_0_0_0_0_01_0_00;
  localparam logic [16:0] C_ID   = 17'b0_0_00_0_0_0_0_0_0_0_0_11_0_00;
  localparam logic [16:0] C_MA   = 17'b0_0_00_0_0_0_0_0_0_0_1_10_0_00;
  localparam logic [16:0] C_MRD  = 17'b0_0_00_1_1_0_0_0_0_0_0_00_0_00;
  localparam logic [16:0] C_WBL  = 17'b0_0_00_0_0_0_0_1_0_1_0_00_0_00;
  localparam logic [16:0] C_MWR  = 17'b0_0_00_1_0_1_0_0_0_0_0_00_0_00;
  localparam logic [16:0] C_EXR  = 17'b0_0_00_0_0_0_0_0_0_0_1_00_0_10;
  localparam logic [16:0] C_WBR  = 17'b0_0_00_0_0_0_0_0_1_1_0_00_0_00;
  localparam logic [16:0] C_BR   = 17'b0_1_01_0_0_0_0_0_0_0_1_00_0_01;
  localparam logic [16:0] C_JMP  = 17'b1_0_10_0_0_0_0_0_0_0_0_00_0_00;
  localparam logic [16:0] C_EXIZ = 17'b0_0_00_0_0_0_0_0_0_0_1_10_1_11;
  localparam logic [16:0] C_EXIS = 17'b0_0_00_0_0_0_0_0_0_0_1_10_0_11;
  localparam logic [16:0] C_WBIZ = 17'b0_0_00_0_0_0_0_0_0_1_0_00_1_00;
  localparam logic [16:0] C_WBIS = 17'b0_0_00_0_0_0_0_0_0_1_0_00_0_00;

  multi_ctrl_fsm #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtZero(ExtZero), .ALUop(ALUop), .state(state), .illegal_op(illegal_op),
    .instr_done(instr_done), .retired(retired)
  );

  always #5 clk = ~clk;

  assign ctl = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ExtZero, ALUop};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] st, input logic [16:0] c,
                         input logic done, input logic [31:0] ret);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".ctl"}, 32'(ctl), 32'(c));
    chk({tag, ".done"}, 32'(instr_done), 32'(done));
    chk({tag, ".retired"}, retired, ret);
  endtask

  task automatic step(input string tag, input logic [3:0] st, input logic [16:0] c,
                      input logic done, input logic [31:0] ret);
    @(posedge clk);
    #1;
    chk_all(tag, st, c, done, ret);
  endtask

  initial begin
    #1;
    chk_all("reset", 4'd0, C_ZERO, 1'b0, 32'd0);
    chk("reset.illegal", 32'(illegal_op), 32'd0);
    #1 rst_n = 1'b1;
    // R-type
    step("r.if",  4'd1, C_IF1, 1'b0, 32'd0);
    step("r.id",  4'd2, C_ID,  1'b0, 32'd0);
    step("r.exr", 4'd7, C_EXR, 1'b0, 32'd0);
    step("r.wbr", 4'd8, C_WBR, 1'b0, 32'd0);
    step("r.ret", 4'd1, C_IF1, 1'b1, 32'd1);
    // lw with two wait cycles in MRD
    opcode = 6'b100011;
    step("lw.id",   4'd2, C_ID,  1'b0, 32'd1);
    step("lw.ma",   4'd3, C_MA,  1'b0, 32'd1);
    step("lw.mrd1", 4'd4, C_MRD, 1'b0, 32'd1);
    mem_ready = 1'b0;
    step("lw.mrd2", 4'd4, C_MRD, 1'b0, 32'd1);
    step("lw.mrd3", 4'd4, C_MRD, 1'b0, 32'd1);
    mem_ready = 1'b1;
    step("lw.wbl",  4'd5, C_WBL, 1'b0, 32'd1);
    step("lw.ret",  4'd1, C_IF1, 1'b1, 32'd2);
    // beq
    opcode = 6'b000100;
    step("beq.id",  4'd2, C_ID,  1'b0, 32'd2);
    step("beq.br",  4'd9, C_BR,  1'b0, 32'd2);
    step("beq.ret", 4'd1, C_IF1, 1'b1, 32'd3);
    // ori
    opcode = 6'b001101;
    step("ori.id",  4'd2,  C_ID,   1'b0, 32'd3);
    step("ori.exi", 4'd11, C_EXIZ, 1'b0, 32'd3);
    step("ori.wbi", 4'd12, C_WBIZ, 1'b0, 32'd3);
    step("ori.ret", 4'd1,  C_IF1,  1'b1, 32'd4);
    // addi
    opcode = 6'b001000;
    step("addi.id",  4'd2,  C_ID,   1'b0, 32'd4);
    step("addi.exi", 4'd11, C_EXIS, 1'b0, 32'd4);
    step("addi.wbi", 4'd12, C_WBIS, 1'b0, 32'd4);
    step("addi.ret", 4'd1,  C_IF1,  1'b1, 32'd5);
    // fetch stall: IRWrite/PCWrite gated by mem_ready
    mem_ready = 1'b0;
    #1 chk("if.stall.ctl", 32'(ctl), 32'(C_IF0));
    step("if.stall", 4'd1, C_IF0, 1'b0, 32'd5);
    mem_ready = 1'b1;
    // illegal opcode
    opcode = 6'b111111;
    step("ill.id", 4'd2, C_ID, 1'b0, 32'd5);
    chk("ill.flag0", 32'(illegal_op), 32'd0);
    step("ill.if", 4'd1, C_IF1, 1'b0, 32'd5);
    chk("ill.flag1", 32'(illegal_op), 32'd1);
    // jump after illegal; flag remains set
    opcode = 6'b000010;
    step("j.id",  4'd2,  C_ID,  1'b0, 32'd5);
    step("j.jmp", 4'd10, C_JMP, 1'b0, 32'd5);
    step("j.ret", 4'd1,  C_IF1, 1'b1, 32'd6);
    chk("ill.sticky", 32'(illegal_op), 32'd1);
    // sw stalled in MWR, then async reset
    opcode = 6'b101011;
    step("sw.id",  4'd2, C_ID, 1'b0, 32'd6);
    step("sw.ma",  4'd3, C_MA, 1'b0, 32'd6);
    mem_ready = 1'b0;
    step("sw.mwr1", 4'd6, C_MWR, 1'b0, 32'd6);
    step("sw.mwr2", 4'd6, C_MWR, 1'b0, 32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk_all("arst", 4'd0, C_ZERO, 1'b0, 32'd0);
    chk("arst.memwrite", 32'(MemWrite), 32'd0);
    chk("arst.illegal", 32'(illegal_op), 32'd0);
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
